// File: rtl/spram_2048_40bit_arbiter.sv
// rtl/spram_2048_40bit_arbiter.sv - round-robin two-port arbiter with zero-fill init for a 2048x40 SPRAM
module spram_2048_40bit_arbiter #(
  parameter int AWIDTH      = 11,
  parameter int DWIDTH      = 40,
  parameter int NUM_WORDS   = 2048,
  parameter int INIT_ENABLE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_wren,
  input  logic [AWIDTH-1:0] a_addr,
  input  logic [DWIDTH-1:0] a_wdata,
  output logic              a_rvalid,
  output logic [DWIDTH-1:0] a_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_wren,
  input  logic [AWIDTH-1:0] b_addr,
  input  logic [DWIDTH-1:0] b_wdata,
  output logic              b_rvalid,
  output logic [DWIDTH-1:0] b_rdata,
  output logic              init_done,
  output logic [AWIDTH-1:0] ram_address,
  output logic              ram_wren,
  output logic [DWIDTH-1:0] ram_data,
  input  logic [DWIDTH-1:0] ram_out
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state;
  logic [AWIDTH-1:0] init_cnt;
  logic [AWIDTH-1:0] addr_q;
  logic              prio;
  logic              a_rvalid_q;
  logic              b_rvalid_q;
  logic              run;
  logic              sweeping;
  logic              grant_a;
  logic              grant_b;

  // Gating with reset keeps every handshake output quiet while reset is held.
  assign run      = !reset && ((state == S_RUN) || (INIT_ENABLE == 0));
  assign sweeping = !reset && (state == S_INIT) && (INIT_ENABLE != 0);

  assign grant_a = run && a_valid && (!b_valid || !prio);
  assign grant_b = run && b_valid && (!a_valid ||  prio);

  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign init_done = run;

  // A read already in flight when reset arrives must not surface.
  assign a_rvalid = a_rvalid_q && !reset;
  assign b_rvalid = b_rvalid_q && !reset;
  assign a_rdata  = ram_out;
  assign b_rdata  = ram_out;

  always_comb begin
    ram_wren    = 1'b0;
    ram_address = addr_q;
    ram_data    = '0;
    if (sweeping) begin
      ram_wren    = 1'b1;
      ram_address = init_cnt;
    end else if (grant_a) begin
      ram_wren    = a_wren;
      ram_address = a_addr;
      ram_data    = a_wdata;
    end else if (grant_b) begin
      ram_wren    = b_wren;
      ram_address = b_addr;
      ram_data    = b_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_INIT;
      init_cnt   <= '0;
      addr_q     <= '0;
      prio       <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      addr_q     <= ram_address;
      a_rvalid_q <= grant_a && !a_wren;
      b_rvalid_q <= grant_b && !b_wren;
      // Priority moves to whichever port lost, so an idle cycle leaves it alone.
      if (grant_a) begin
        prio <= 1'b1;
      end else if (grant_b) begin
        prio <= 1'b0;
      end
      case (state)
        S_INIT: begin
          if (INIT_ENABLE == 0) begin
            state <= S_RUN;
          end else begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == AWIDTH'(NUM_WORDS - 1)) begin
              state <= S_RUN;
            end
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_spram_2048_40bit_arbiter.sv
// tb/tb_spram_2048_40bit_arbiter.sv - directed vector bench for the SPRAM arbiter
module tb_spram_2048_40bit_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, a_wren, b_valid, b_wren;
  logic [10:0] a_addr, b_addr;
  logic [39:0] a_wdata, b_wdata;
  logic        a_ready, b_ready, a_rvalid, b_rvalid, init_done, ram_wren;
  logic [39:0] a_rdata, b_rdata, ram_data, ram_out;
  logic [10:0] ram_address;

  logic        reset2;
  logic        a2_valid, a2_wren, b2_valid, b2_wren;
  logic [10:0] a2_addr, b2_addr;
  logic [39:0] a2_wdata, b2_wdata;
  logic        a2_ready, b2_ready, a2_rvalid, b2_rvalid, init_done2, ram_wren2;
  logic [39:0] a2_rdata, b2_rdata, ram_data2, ram_out2;
  logic [10:0] ram_address2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spram_2048_40bit_arbiter dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_wren(a_wren), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_wren(b_wren), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .init_done(init_done), .ram_address(ram_address), .ram_wren(ram_wren),
    .ram_data(ram_data), .ram_out(ram_out)
  );

  spram_2048_40bit_arbiter #(.INIT_ENABLE(0)) dut2 (
    .clk(clk), .reset(reset2),
    .a_valid(a2_valid), .a_ready(a2_ready), .a_wren(a2_wren), .a_addr(a2_addr),
    .a_wdata(a2_wdata), .a_rvalid(a2_rvalid), .a_rdata(a2_rdata),
    .b_valid(b2_valid), .b_ready(b2_ready), .b_wren(b2_wren), .b_addr(b2_addr),
    .b_wdata(b2_wdata), .b_rvalid(b2_rvalid), .b_rdata(b2_rdata),
    .init_done(init_done2), .ram_address(ram_address2), .ram_wren(ram_wren2),
    .ram_data(ram_data2), .ram_out(ram_out2)
  );

  // Single-port RAM: registered read, output held during writes.
  logic [39:0] mem [0:2047];
  always @(posedge clk) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    else          ram_out <= mem[ram_address];
  end

  typedef struct {
    logic        av, aw;
    logic [10:0] aa;
    logic [39:0] ad;
    logic        bv, bw;
    logic [10:0] ba;
    logic [39:0] bd;
    logic        e_ar, e_br, e_arv, e_brv;
    logic [39:0] e_rd;
    logic        e_wren;
    logic [10:0] e_addr;
  } vec_t;

  localparam logic [39:0] DAB = 40'hAB_CDEF_0123;
  localparam logic [39:0] D1  = 40'h11_1111_1111;
  localparam logic [39:0] D2  = 40'h22_2222_2222;

  function automatic vec_t mk(
    input logic av, input logic aw, input logic [10:0] aa, input logic [39:0] ad,
    input logic bv, input logic bw, input logic [10:0] ba, input logic [39:0] bd,
    input logic ear, input logic ebr, input logic earv, input logic ebrv,
    input logic [39:0] erd, input logic ewr, input logic [10:0] eaddr);
    vec_t v;
    v.av = av; v.aw = aw; v.aa = aa; v.ad = ad;
    v.bv = bv; v.bw = bw; v.ba = ba; v.bd = bd;
    v.e_ar = ear; v.e_br = ebr; v.e_arv = earv; v.e_brv = ebrv;
    v.e_rd = erd; v.e_wren = ewr; v.e_addr = eaddr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  vec_t vecs [15];
  int   wren_cnt, seq_err, low_cnt, rdy_err;

  initial begin
    vecs[0]  = mk(1,0,11'd5,  0,   0,0,0,    0,  1,0,0,0, 0,   0,11'd5);
    vecs[1]  = mk(0,0,0,      0,   0,0,0,    0,  0,0,1,0, 0,   0,11'd5);
    vecs[2]  = mk(1,1,11'd100,DAB, 0,0,0,    0,  1,0,0,0, 0,   1,11'd100);
    vecs[3]  = mk(1,0,11'd100,0,   0,0,0,    0,  1,0,0,0, 0,   0,11'd100);
    vecs[4]  = mk(0,0,0,      0,   0,0,0,    0,  0,0,1,0, DAB, 0,11'd100);
    vecs[5]  = mk(0,0,0,      0,   1,1,11'd2,D2, 0,1,0,0, 0,   1,11'd2);
    vecs[6]  = mk(1,1,11'd1,  D1,  0,0,0,    0,  1,0,0,0, 0,   1,11'd1);
    vecs[7]  = mk(0,0,0,      0,   1,0,11'd2,0,  0,1,0,0, 0,   0,11'd2);
    vecs[8]  = mk(0,0,0,      0,   1,0,11'd2,0,  0,1,0,1, D2,  0,11'd2);
    vecs[9]  = mk(0,0,0,      0,   1,0,11'd2,0,  0,1,0,1, D2,  0,11'd2);
    vecs[10] = mk(1,0,11'd1,  0,   1,0,11'd2,0,  1,0,0,1, D2,  0,11'd1);
    vecs[11] = mk(1,0,11'd1,  0,   1,0,11'd2,0,  0,1,1,0, D1,  0,11'd2);
    vecs[12] = mk(1,0,11'd1,  0,   1,0,11'd2,0,  1,0,0,1, D2,  0,11'd1);
    vecs[13] = mk(1,0,11'd1,  0,   1,0,11'd2,0,  0,1,1,0, D1,  0,11'd2);
    vecs[14] = mk(0,0,0,      0,   0,0,0,    0,  0,0,0,1, D2,  0,11'd2);

    reset = 1; a_valid = 0; a_wren = 0; a_addr = 0; a_wdata = 0;
    b_valid = 0; b_wren = 0; b_addr = 0; b_wdata = 0;
    reset2 = 1; a2_valid = 0; a2_wren = 0; a2_addr = 0; a2_wdata = 0;
    b2_valid = 0; b2_wren = 0; b2_addr = 0; b2_wdata = 0; ram_out2 = 0;

    repeat (2) @(posedge clk);
    #1; a_valid = 1; b_valid = 1;
    @(negedge clk);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_b_rvalid", b_rvalid, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_ram_wren", ram_wren, 0);
    chk("rst_init_done2", init_done2, 0);

    // No-init instance: usable in the very first cycle after reset.
    @(posedge clk); #1;
    a_valid = 0; b_valid = 0;
    reset2 = 0; a2_valid = 1; a2_wren = 1; a2_addr = 11'd7; a2_wdata = 40'h77_0000_0077;
    @(negedge clk);
    chk("noinit_done", init_done2, 1);
    chk("noinit_a_ready", a2_ready, 1);
    chk("noinit_wren", ram_wren2, 1);
    chk("noinit_addr", ram_address2, 11'd7);
    chk("noinit_data", ram_data2, 40'h77_0000_0077);

    @(posedge clk); #1;
    a2_valid = 0; reset = 0; a_valid = 1; a_addr = 11'd9;
    wren_cnt = 0; seq_err = 0; low_cnt = 0; rdy_err = 0;
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk);
      if (ram_wren) wren_cnt++;
      if (!ram_wren || ram_address != 11'(i) || ram_data != 40'd0) seq_err++;
      if (!init_done) low_cnt++;
      if (a_ready || a_rvalid) rdy_err++;
      @(posedge clk); #1;
    end
    a_valid = 0;
    chk("init_wren_cycles", wren_cnt, 2048);
    chk("init_sweep_errors", seq_err, 0);
    chk("init_done_low_cycles", low_cnt, 2048);
    chk("init_no_grant", rdy_err, 0);
    @(negedge clk);
    chk("init_done_high", init_done, 1);
    chk("run_idle_wren", ram_wren, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      a_valid = vecs[i].av; a_wren = vecs[i].aw; a_addr = vecs[i].aa; a_wdata = vecs[i].ad;
      b_valid = vecs[i].bv; b_wren = vecs[i].bw; b_addr = vecs[i].ba; b_wdata = vecs[i].bd;
      @(negedge clk);
      chk($sformatf("v%0d_a_ready", i), a_ready, vecs[i].e_ar);
      chk($sformatf("v%0d_b_ready", i), b_ready, vecs[i].e_br);
      chk($sformatf("v%0d_a_rvalid", i), a_rvalid, vecs[i].e_arv);
      chk($sformatf("v%0d_b_rvalid", i), b_rvalid, vecs[i].e_brv);
      chk($sformatf("v%0d_ram_wren", i), ram_wren, vecs[i].e_wren);
      chk($sformatf("v%0d_ram_address", i), ram_address, vecs[i].e_addr);
      if (vecs[i].e_arv) chk($sformatf("v%0d_a_rdata", i), a_rdata, vecs[i].e_rd);
      if (vecs[i].e_brv) chk($sformatf("v%0d_b_rdata", i), b_rdata, vecs[i].e_rd);
      if (vecs[i].e_wren)
        chk($sformatf("v%0d_ram_data", i), ram_data, vecs[i].e_ar ? vecs[i].ad : vecs[i].bd);
      @(posedge clk); #1;
    end
    a_valid = 0; b_valid = 0;

    // Read accepted, then reset lands before its response.
    a_valid = 1; a_wren = 0; a_addr = 11'd100;
    @(negedge clk);
    chk("midrst_accept", a_ready, 1);
    @(posedge clk); #1;
    a_valid = 0; reset = 1;
    @(negedge clk);
    chk("midrst_a_rvalid", a_rvalid, 0);
    chk("midrst_init_done", init_done, 0);
    chk("midrst_ram_wren", ram_wren, 0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("postrst_a_rvalid", a_rvalid, 0);
    chk("postrst_b_rvalid", b_rvalid, 0);
    chk("postrst_init_done", init_done, 0);
    chk("postrst_wren", ram_wren, 1);
    chk("postrst_addr0", ram_address, 11'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("postrst_addr1", ram_address, 11'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spram_2048_40bit_arbiter.md
# spram_2048_40bit_arbiter

Two-port round-robin arbiter and initialiser in front of one `spram_2048_40bit` single-port RAM, 2048 x 40. Two independent requesters share the RAM through valid/ready handshakes, with at most one access per cycle. After reset the block optionally zero-fills the whole RAM before granting any request. It sits between the compute units that share a buffer and the RAM instance; all `ram_*` ports connect directly to that instance.

## Interface
Parameters:
- AWIDTH, 11, address width
- DWIDTH, 40, data width
- NUM_WORDS, 2048, words cleared during init
- INIT_ENABLE, 1, 1 = zero-fill RAM after reset; 0 = skip init

Ports:
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- a_valid  in  1  requester A access request
- a_ready  out  1  A request accepted this cycle
- a_wren  in  1  1 = write, 0 = read
- a_addr  in  AWIDTH  A address
- a_wdata  in  DWIDTH  A write data
- a_rvalid  out  1  A read data valid on a_rdata
- a_rdata  out  DWIDTH  A read data
- b_valid, b_ready, b_wren, b_addr, b_wdata, b_rvalid, b_rdata: same as A, for requester B
- init_done  out  1  high once RAM is usable; stays high until next reset
- ram_address  out  AWIDTH  to RAM address
- ram_wren  out  1  to RAM wren
- ram_data  out  DWIDTH  to RAM data
- ram_out  in  DWIDTH  from RAM out; registered, valid 1 cycle after a read

## Operation
- States: INIT, RUN. Reset forces INIT with init counter 0. If INIT_ENABLE=0, the block moves to RUN on the first cycle after reset.
- INIT:
  - ram_wren=1, ram_address=counter, ram_data=0.
  - The counter increments every cycle. After the write to NUM_WORDS-1, the state becomes RUN.
  - a_ready, b_ready, a_rvalid, b_rvalid are all 0.
- RUN grant rule: a 1-bit priority pointer `prio` (reset 0 = A) selects the winner.
  - Both valid: the port named by prio wins.
  - One valid: that port wins.
  - No valid: no grant, and prio is unchanged.
- After any grant, prio points to the port that did not win.
- Granted port: its ready = 1, combinational in the same cycle. Its wren/addr/wdata drive ram_wren/ram_address/ram_data. The loser's ready = 0; it must hold its request stable until granted.
- No grant: ram_wren=0 and ram_address holds its previous value, so no spurious write occurs.
- Read response:
  - A read granted in cycle N gives x_rvalid=1 in cycle N+1 for that port only; the other port's rvalid=0.
  - a_rdata and b_rdata are both wired to ram_out. Consumers sample only when their rvalid is high.
- Writes produce no response. The RAM holds `out` during write cycles, so a write in N+1 does not corrupt the read data of cycle N+1.
- Every request in RUN is granted in at most 2 cycles, so neither port can starve.

## Timing
- Reset values: a_ready=b_ready=0, a_rvalid=b_rvalid=0, init_done=0, ram_wren=0 while reset is high, prio=0, counter=0.
- INIT_ENABLE=1: the init writes occupy cycles 1..NUM_WORDS after reset deassertion. init_done rises in cycle NUM_WORDS+1, the first cycle of RUN. Requests are grantable from that cycle.
- INIT_ENABLE=0: init_done=1 and requests are grantable from the first cycle after reset.
- Handshake latency: a request is accepted in the cycle it is presented if it wins. Read latency is 1 cycle from acceptance to rvalid.
- Throughput: 1 access per cycle total. Back-to-back reads from one port give rvalid every cycle.
- Reset mid-operation: a read accepted in the cycle before reset produces no rvalid. Both rvalids are 0 in the cycle after the reset edge, and init restarts from address 0.
- Address wrap: not applicable; addresses are used as given, and full AWIDTH range is legal.

## Test plan
- Reset, INIT_ENABLE=1, no requests:
  - init_done low for 2048 cycles, then high.
  - ram_wren high for exactly 2048 cycles on addresses 0..2047 with data 0.
  - A read of address 5 afterwards returns 0.
- A writes 0xAB_CDEF_0123 to address 100. Next cycle A reads 100.
  - a_ready high both cycles.
  - a_rvalid=1 and a_rdata=0xAB_CDEF_0123 one cycle after the read; b_rvalid stays 0.
- A and B both hold valid reads (A addr 1, B addr 2) for 4 cycles.
  - Grants alternate A, B, A, B starting with A.
  - The rvalids alternate one cycle later with the correct data.
- Only B is valid for 3 cycles, then both are valid.
  - B granted 3 times.
  - Then A wins first, because prio now points to A.
- A read is accepted in cycle N and reset is asserted in cycle N+1.
  - No rvalid is produced.
  - init_done=0 and the init sweep restarts at address 0.
- INIT_ENABLE=0:
  - init_done=1 in the first cycle after reset.
  - A write presented in that cycle is granted immediately.
